// File: rtl/mean_frame_collector_pkg.sv
// Shared types and width helpers for the mean-block frame collector.
// The helpers derive widths from the per-instance parameters N and B.
package mean_pkg;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} mean_col_state_t;

  // Running-sum width: a frame of n samples of b bits never overflows this.
  function automatic int sum_width(input int b, input int n);
    return b + $clog2(n);
  endfunction

  // Width of a counter holding 0..n (at least one bit).
  function automatic int count_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mean_frame_collector_slot_counter.sv
// Modulo-N slot counter for the frame collector: increment, sync clear and
// load-1 (restart) controls, plus a flag marking the final slot.
module mean_slot_counter
  import mean_pkg::*;
#(
  parameter int N  = 5,
  parameter int CW = count_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  input  logic          load1,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  // With a single slot the restart value wraps straight back to zero.
  localparam logic [CW-1:0] ONE  = (N == 1) ? {CW{1'b0}} : CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign last = (count == LAST);

  // Slot index register; load1 wins over inc so a restart lands on slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= ZERO;
    end else if (clr) begin
      count <= ZERO;
    end else if (load1) begin
      count <= ONE;
    end else if (inc) begin
      count <= last ? ZERO : count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mean_frame_collector.sv
// Packs N serial samples into a parallel frame for the mean block.
// Optional FRAME_SUM_EN adds the o_sum output and its running accumulator.
module mean_frame_collector
  import mean_pkg::*;
#(
  parameter int N = 5,
  parameter int B = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_dval,
  input  logic [B-1:0]              i_data,
  input  logic                      i_sof,
  output logic                      o_dval,
  output logic [B-1:0]              o_data [N],
  output logic [count_width(N)-1:0] o_count,
  output logic                      o_err
`ifdef FRAME_SUM_EN
  ,
  output logic [sum_width(B, N)-1:0] o_sum
`endif
);

  localparam int   CW     = count_width(N);
  localparam logic SINGLE = (N == 1);
  localparam logic MULTI  = (N > 1);

  mean_col_state_t state, next_state;
  logic [CW-1:0]   count;
  logic            last;
  logic            restart;
  logic            complete;
  logic            frame_start;
  logic [B-1:0]    shadow [N];

  mean_slot_counter #(.N(N), .CW(CW)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (i_dval & ~restart),
    .clr   (1'b0),
    .load1 (restart),
    .count (count),
    .last  (last)
  );

  assign o_count = count;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; a restart keeps us filling from slot 1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_dval && MULTI) next_state = FILL;
        else                 next_state = IDLE;
      end
      FILL: begin
        if (restart)       next_state = FILL;
        else if (complete) next_state = IDLE;
        else               next_state = FILL;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM decode; i_sof on the final slot is a restart, never a completion.
  always_comb begin
    restart     = 1'b0;
    complete    = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        frame_start = i_dval;
        complete    = i_dval & SINGLE;
      end
      FILL: begin
        restart  = i_dval & i_sof;
        complete = i_dval & ~i_sof & last;
      end
      default: begin
        restart     = 1'b0;
        complete    = 1'b0;
        frame_start = 1'b0;
      end
    endcase
  end

  // Shadow capture of the partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) shadow[i] <= {B{1'b0}};
    end else if (restart) begin
      shadow[0] <= i_data;
    end else if (i_dval) begin
      shadow[count] <= i_data;
    end else begin
      shadow <= shadow;
    end
  end

  // Output registers: the final sample bypasses the shadow into slot N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dval <= 1'b0;
      o_err  <= 1'b0;
      for (int i = 0; i < N; i++) o_data[i] <= {B{1'b0}};
    end else begin
      o_dval <= complete;
      o_err  <= restart;
      if (complete) begin
        for (int i = 0; i < N - 1; i++) o_data[i] <= shadow[i];
        o_data[N-1] <= i_data;
      end else begin
        o_data <= o_data;
      end
    end
  end

`ifdef FRAME_SUM_EN
  localparam int B_SUM = sum_width(B, N);

  logic [B_SUM-1:0] acc;

  // Running sum; a frame start reloads it so stale partial sums never leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= {B_SUM{1'b0}};
      o_sum <= {B_SUM{1'b0}};
    end else begin
      if (frame_start || restart) begin
        acc <= B_SUM'(i_data);
      end else if (i_dval) begin
        acc <= acc + B_SUM'(i_data);
      end else begin
        acc <= acc;
      end
      if (complete) begin
        o_sum <= (frame_start ? {B_SUM{1'b0}} : acc) + B_SUM'(i_data);
      end else begin
        o_sum <= o_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mean_frame_collector.sv
// Self-checking bench: directed scenarios plus random traffic on an N=5 and an
// N=1 instance, both compared against a queue-based frame model.
module tb_mean_frame_collector;
  import mean_pkg::*;

  localparam int N  = 5;
  localparam int B  = 10;
  localparam int CW = count_width(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_dval, i_sof;
  logic [B-1:0] i_data;

  logic         o_dval, o_err;
  logic [B-1:0] o_data [N];
  logic [CW-1:0] o_count;
  logic         s_dval, s_err;
  logic [B-1:0] s_data [1];
  logic [0:0]   s_count;
`ifdef FRAME_SUM_EN
  logic [sum_width(B, N)-1:0] o_sum;
  logic [sum_width(B, 1)-1:0] s_sum;
`endif

  mean_frame_collector #(.N(N), .B(B)) dut (
    .clk(clk), .rst_n(rst_n), .i_dval(i_dval), .i_data(i_data), .i_sof(i_sof),
    .o_dval(o_dval), .o_data(o_data), .o_count(o_count), .o_err(o_err)
`ifdef FRAME_SUM_EN
    , .o_sum(o_sum)
`endif
  );

  mean_frame_collector #(.N(1), .B(B)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_dval(i_dval), .i_data(i_data), .i_sof(i_sof),
    .o_dval(s_dval), .o_data(s_data), .o_count(s_count), .o_err(s_err)
`ifdef FRAME_SUM_EN
    , .o_sum(s_sum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int q[$];
  int frame [N];
  int exp_dval, exp_err, exp_sum;
  int frame1, exp_dval1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < N; i++) frame[i] = 0;
    exp_dval = 0; exp_err = 0; exp_sum = 0;
    frame1 = 0; exp_dval1 = 0;
  endfunction

  function automatic void model_step(input logic dv, input logic sf, input int d);
    exp_dval = 0;
    exp_err  = 0;
    exp_dval1 = dv;
    if (dv) begin
      frame1 = d;
      if (sf && q.size() != 0) begin
        exp_err = 1;
        q.delete();
      end
      q.push_back(d);
      if (q.size() == N) begin
        exp_sum = 0;
        for (int i = 0; i < N; i++) begin
          frame[i] = q[i];
          exp_sum += q[i];
        end
        exp_dval = 1;
        q.delete();
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_dval"}, 32'(o_dval), 32'(exp_dval));
    chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
    chk({tag, "_count"}, 32'(o_count), 32'(q.size()));
    for (int i = 0; i < N; i++) chk({tag, "_data"}, 32'(o_data[i]), 32'(frame[i]));
    chk({tag, "_n1_dval"}, 32'(s_dval), 32'(exp_dval1));
    chk({tag, "_n1_err"}, 32'(s_err), 32'd0);
    chk({tag, "_n1_count"}, 32'(s_count), 32'd0);
    chk({tag, "_n1_data"}, 32'(s_data[0]), 32'(frame1));
`ifdef FRAME_SUM_EN
    chk({tag, "_sum"}, 32'(o_sum), 32'(exp_sum));
    chk({tag, "_n1_sum"}, 32'(s_sum), 32'(frame1));
`endif
  endtask

  task automatic step(input string tag, input logic dv, input logic sf, input int d);
    i_dval = dv;
    i_sof  = sf;
    i_data = B'(d);
    @(posedge clk);
    #1;
    model_step(dv, sf, d);
    check_all(tag);
  endtask

  task automatic apply_reset();
    i_dval = 1'b0;
    i_sof  = 1'b0;
    i_data = '0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // 1: one frame back-to-back
    step("t1", 1'b1, 1'b0, 10);
    step("t1", 1'b1, 1'b0, 20);
    step("t1", 1'b1, 1'b0, 30);
    step("t1", 1'b1, 1'b0, 40);
    step("t1", 1'b1, 1'b0, 50);
    chk("t1_pulse", 32'(o_dval), 32'd1);
    chk("t1_last", 32'(o_data[4]), 32'd50);
`ifdef FRAME_SUM_EN
    chk("t1_sum150", 32'(o_sum), 32'd150);
`endif
    step("t1_idle", 1'b0, 1'b0, 0);

    // 2: two frames with no bubble
    for (int k = 1; k <= 10; k++) step("t2", 1'b1, 1'b0, k);
    chk("t2_first", 32'(o_data[0]), 32'd6);

    // 3: gaps between samples hold the count
    for (int k = 1; k <= 3; k++) begin
      step("t3", 1'b1, 1'b0, k);
      chk("t3_hold", 32'(o_count), 32'(k));
      repeat (3) step("t3_gap", 1'b0, (k == 2) ? 1'b1 : 1'b0, 0);
    end
    step("t3", 1'b1, 1'b0, 4);
    step("t3", 1'b1, 1'b0, 5);

    // 4: restart mid-frame
    step("t4", 1'b1, 1'b0, 7);
    step("t4", 1'b1, 1'b0, 8);
    step("t4", 1'b1, 1'b0, 9);
    step("t4_sof", 1'b1, 1'b1, 100);
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_cnt1", 32'(o_count), 32'd1);
    for (int k = 101; k <= 104; k++) step("t4", 1'b1, 1'b0, k);
    chk("t4_slot0", 32'(o_data[0]), 32'd100);

    // sof on the final slot is a restart, not a completion
    for (int k = 0; k < 4; k++) step("t4b", 1'b1, 1'b0, 200 + k);
    step("t4b_sof", 1'b1, 1'b1, 300);
    chk("t4b_nodval", 32'(o_dval), 32'd0);
    // sof on an empty frame is a plain accept
    for (int k = 0; k < 4; k++) step("t4c", 1'b1, 1'b0, k);
    step("t4c_sof0", 1'b1, 1'b1, 400);
    chk("t4c_noerr", 32'(o_err), 32'd0);

    // 5: reset drops the partial frame
    for (int k = 0; k < 3; k++) step("t5_pre", 1'b1, 1'b0, 900 + k);
    apply_reset();
    for (int k = 1; k <= 5; k++) step("t5", 1'b1, 1'b0, k);
    chk("t5_data4", 32'(o_data[4]), 32'd5);

    // 6: extreme sample values (N=1 instance checks each completion)
    step("t6", 1'b1, 1'b0, 3);
    chk("t6_n1_3", 32'(s_data[0]), 32'd3);
    step("t6", 1'b1, 1'b1, 1023);
    chk("t6_n1_1023", 32'(s_data[0]), 32'd1023);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step("rnd", ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 1023)));
    end
    step("rnd_end", 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
